// File: rtl/bidir_bus_port.sv
// Clocked bidirectional pad port: registered drive/enable, synchronised receive path,
// and a turnaround FSM that idles the bus for TURN_CYCLES on every direction change.
module bidir_bus_port #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      TURN_CYCLES = 2,
    parameter bit               IN_SYNC     = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic             dir_req_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_c_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             bus_oe_o,
    output logic             busy_o,
    inout  wire  [WIDTH-1:0] bidir_io
);

    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] TURN_LOAD = (TURN_CYCLES == 0) ? '0 : CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_oe_q;
    logic             busy_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] cap_q;
    logic             cap_tag_q;

    // Direction FSM; outputs are updated on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RX;
            cnt_q    <= '0;
            bus_oe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                ST_RX: begin
                    if (dir_req_i) begin
                        if (TURN_CYCLES == 0) begin
                            state_q  <= ST_TX;
                            bus_oe_q <= 1'b1;
                        end else begin
                            state_q <= ST_TURN_TX;
                            cnt_q   <= TURN_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_TURN_TX: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_TX;
                        bus_oe_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_TX: begin
                    if (!dir_req_i) begin
                        bus_oe_q <= 1'b0;
                        if (TURN_CYCLES == 0) begin
                            state_q <= ST_RX;
                        end else begin
                            state_q <= ST_TURN_RX;
                            cnt_q   <= TURN_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_TURN_RX: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RX;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_RX;
                    bus_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready_c_o = (state_q == ST_TX) & dir_req_i & ce_i;

    // Transmit register holds the last accepted word between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= RESET_VAL;
        end else if (tx_ready_c_o && tx_valid_i) begin
            tx_q <= tx_data_i;
        end
    end

    // First capture stage; the tag records whether the sample was taken in RX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            cap_tag_q <= 1'b0;
        end else if (ce_i) begin
            cap_q     <= bidir_io;
            cap_tag_q <= (state_q == ST_RX);
        end
    end

    generate
        if (IN_SYNC) begin : g_sync
            logic [WIDTH-1:0] sync_q;
            logic             sync_tag_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q     <= '0;
                    sync_tag_q <= 1'b0;
                end else if (ce_i) begin
                    sync_q     <= cap_q;
                    sync_tag_q <= cap_tag_q;
                end
            end

            assign rx_data_o  = sync_q;
            assign rx_valid_o = sync_tag_q;
        end else begin : g_nosync
            assign rx_data_o  = cap_q;
            assign rx_valid_o = cap_tag_q;
        end
    endgenerate

    assign bus_oe_o = bus_oe_q;
    assign busy_o   = busy_q;
    assign bidir_io = bus_oe_q ? tx_q : {WIDTH{1'bz}};

endmodule
